// File: rtl/hdmi_pix_fifo.sv
// Frame-aligned FWFT pixel buffer between the camera pipeline and the HDMI output stage.
// Output is released only at a vs rising edge once primed; overflow/underflow flush and resync to the next sof.
module hdmi_pix_fifo #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned AW          = 11,
  parameter int unsigned PRIME_LEVEL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              vs,
  input  logic              fifo_rd_en,
  output logic [DATA_W-1:0] fifo_rd_data,
  output logic [AW:0]       level,
  output logic              running,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] LEVEL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEVEL_PRIME = (AW+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {
    WAIT_SOF,
    FILL,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              vs_d, vs_rise;
  logic              full, empty;
  logic              push, pop;
  logic              ovf_evt, udf_evt;

  assign vs_rise = vs & ~vs_d;
  assign full    = (level == LEVEL_FULL);
  assign empty   = (level == '0);

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    pop      = 1'b0;
    ovf_evt  = 1'b0;
    udf_evt  = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (in_valid && in_sof) begin
          push     = 1'b1;
          state_nx = FILL;
        end
      end
      FILL: begin
        // Overflow takes priority over a coincident vs release.
        if (in_valid && full) begin
          ovf_evt  = 1'b1;
          state_nx = FLUSH;
        end else begin
          push = in_valid;
          if (vs_rise && (level >= LEVEL_PRIME)) state_nx = RUN;
        end
      end
      RUN: begin
        if (fifo_rd_en && empty) begin
          udf_evt  = 1'b1;
          state_nx = FLUSH;
        end else if (in_valid && full && !fifo_rd_en) begin
          ovf_evt  = 1'b1;
          state_nx = FLUSH;
        end else begin
          pop  = fifo_rd_en;
          push = in_valid;
        end
      end
      FLUSH: state_nx = WAIT_SOF;
      default: state_nx = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_SOF;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      vs_d      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nx;
      vs_d  <= vs;
      if (state == FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
      if (ovf_evt) overflow  <= 1'b1;
      if (udf_evt) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

  // Asynchronous head read gives the consumer zero-cycle latency.
  assign running      = (state == RUN);
  assign fifo_rd_data = (running && !empty) ? mem[rd_ptr] : '0;

endmodule

// File: doc/hdmi_pix_fifo.md
Name: hdmi_pix_fifo

Overview:
- Frame-aligned pixel buffer between the camera pixel pipeline (write side) and the HDMI output stage (read side). Both sides run on one clock.
- Accepts a non-backpressurable 16-bit pixel stream with a start-of-frame marker.
- Serves words in first-word-fall-through (FWFT) style to the HDMI stage, whose read enable is its active-video flag.
- Starts reading only at a vertical-sync boundary, with the buffer primed, so camera frame starts land on display frame starts. Recovers automatically from overflow or underflow.

Parameters:
- DATA_W, 16, pixel word width.
- AW, 11, address width; depth = 2**AW words.
- PRIME_LEVEL, 1024, minimum fill level (words) needed to release output at a vs edge; must be < 2**AW.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input pixel strobe.
- in_data  in  DATA_W  input pixel.
- in_sof  in  1  qualifies in_valid; marks the first pixel of a frame.
- vs  in  1  vertical sync from the timing generator, active-high.
- fifo_rd_en  in  1  pop request (HDMI active video).
- fifo_rd_data  out  DATA_W  head word; FWFT.
- level  out  AW+1  current occupancy, 0..2**AW.
- running  out  1  high in RUN.
- overflow  out  1  sticky; write attempted while full.
- underflow  out  1  sticky; pop attempted while empty in RUN.

Behaviour:
- Storage:
  - 2**AW x DATA_W dual-pointer RAM; pointers wrap modulo 2**AW.
  - level is tracked with a separate AW+1-bit counter.
  - Same-cycle push and pop leave level unchanged.
- FWFT output:
  - When level > 0, fifo_rd_data shows the head word in the same cycle fifo_rd_en is sampled.
  - A pop advances the head; the next word is visible the following cycle.
  - Implementation may use a registered head plus prefetch. Zero-cycle read latency as seen by the consumer is mandatory.
- Output gating:
  - fifo_rd_data = 0 whenever running = 0 or level = 0.
  - fifo_rd_en is ignored outside RUN; no pop occurs.
- vs edge detection: vs_rise = vs & ~vs_d, with vs_d registered.
- States:
  - WAIT_SOF: writes discarded. On in_valid & in_sof, write that pixel and go to FILL.
  - FILL: all valid pixels written. On vs_rise with level >= PRIME_LEVEL, go to RUN; pops are honoured from the next cycle. On vs_rise with level < PRIME_LEVEL, stay in FILL.
  - RUN: push on in_valid, pop on fifo_rd_en. in_sof in RUN is a normal write.
  - FLUSH: one cycle. Pointers and level go to 0, then go to WAIT_SOF.
- Error transitions:
  - in_valid while level = 2**AW with no same-cycle pop, in FILL or RUN: drop the word, set overflow, go to FLUSH.
  - A push and pop in the same cycle at full is legal.
  - fifo_rd_en in RUN with level = 0: fifo_rd_data = 0, set underflow, go to FLUSH.
  - A push in that same cycle is dropped.
- Sticky flags: overflow and underflow clear only on rst.
- Reset (rst sampled high at a clk edge):
  - State = WAIT_SOF, pointers = 0, level = 0.
  - fifo_rd_data = 0, running = 0, overflow = 0, underflow = 0, vs_d = 0.
  - rst mid-frame abandons buffered data; no pop or write occurs in the reset cycle.
- Simultaneous events:
  - vs_rise and overflow in the same cycle in FILL: overflow wins (FLUSH).
  - in_sof arriving in FLUSH: discarded. The next sof is required.

Test Plan (bench parameters AW=4, PRIME_LEVEL=8):
- Prime/release:
  - Stimulus: rst, then sof + 10 pixels 0x0001..0x000A, then a vs pulse.
  - Response: running=1 one cycle after vs_rise.
  - Then 10 pops return 0x0001..0x000A in order, each on its rd_en cycle. level ends at 0 and no flags are set.
- Under-primed:
  - Stimulus: sof + 5 pixels, then vs pulse.
  - Response: running stays 0 and fifo_rd_data=0 while rd_en toggles.
  - After 3 more pixels and the next vs: running=1.
- Pre-sof discard:
  - Stimulus: 4 pixels with in_sof=0, then sof pixel 0x00AA.
  - Response: level=1 and the head word is 0x00AA.
- Overflow:
  - Stimulus: in FILL, write 17 pixels without vs.
  - Response: overflow=1 on the 17th, FLUSH, then level=0 and state WAIT_SOF.
  - A later sof frame primes and runs normally with overflow still 1.
- Underflow:
  - Stimulus: in RUN with level=2, hold rd_en for 3 cycles.
  - Response: 2 valid words, then data 0, underflow=1, running=0, level=0.
- Wrap/concurrency:
  - Stimulus: in RUN, push and pop every cycle for 40 cycles at level 8.
  - Response: level holds 8 and the data sequence is intact across pointer wrap.
  - Then assert rst mid-stream: the next cycle shows all outputs at reset values.
